// File: rtl/uart_tx_fifo_if.sv
// CPU write port and transmitter handshake for the UART transmit FIFO.
// The master side is the bus and the transmitter; the FIFO is the slave.
interface uart_tx_fifo_if #(
   parameter int DB = 8,
   parameter int AW = 4
);
   logic          wr;
   logic [DB-1:0] w_data;
   logic          tx_done;
   logic [DB-1:0] d_in;
   logic          tx_start;
   logic          tx_full;
   logic          tx_empty;
   logic [AW:0]   level;
   logic          overflow;

   modport master (
      output wr, w_data, tx_done,
      input  d_in, tx_start, tx_full, tx_empty, level, overflow
   );

   modport slave (
      input  wr, w_data, tx_done,
      output d_in, tx_start, tx_full, tx_empty, level, overflow
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular transmit buffer feeding the UART TX shift engine one word per frame.
//   state | meaning
//   IDLE  | transmitter idle; pops the oldest word as soon as one is stored
//   START | tx_start high for this single cycle, d_in holds the popped word
//   WAIT  | frame in flight; leaves on the tx_done pulse
module uart_tx_fifo #(
   parameter int DB      = 8,
   parameter int AW      = 4,
   parameter int WR_MODE = 0
) (
   input logic         clk,
   input logic         reset_n,
   uart_tx_fifo_if.slave bus
);
   localparam int          DEPTH    = 2 ** AW;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

   state_t        state;
   logic [DB-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          wr_q;
   logic [DB-1:0] d_in_r;
   logic          tx_start_r;
   logic          overflow_r;

   logic          wr_req;
   logic          wr_ok;
   logic          pop;

   // Full is judged on the count before the edge, so a write racing a pop
   // from a full buffer is still rejected.
   always_comb begin
      wr_req = (WR_MODE != 0) ? (bus.wr & ~wr_q) : bus.wr;
      wr_ok  = wr_req && (count != FULL_CNT);
      pop    = (state == IDLE) && (count != '0);
   end

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_ptr] <= bus.w_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         wr_q       <= 1'b0;
         d_in_r     <= '0;
         tx_start_r <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         wr_q       <= bus.wr;
         tx_start_r <= 1'b0;
         overflow_r <= wr_req && !wr_ok;

         if (wr_ok)
            wr_ptr <= wr_ptr + 1'b1;

         case ({wr_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         case (state)
            IDLE: begin
               if (pop) begin
                  d_in_r     <= mem[rd_ptr];
                  rd_ptr     <= rd_ptr + 1'b1;
                  tx_start_r <= 1'b1;
                  state      <= START;
               end
            end
            START: state <= WAIT;
            WAIT: begin
               if (bus.tx_done)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.d_in     = d_in_r;
   assign bus.tx_start = tx_start_r;
   assign bus.overflow = overflow_r;
   assign bus.level    = count;
   assign bus.tx_full  = (count == FULL_CNT);
   assign bus.tx_empty = (count == '0);
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised transmit buffer between the CPU-side write port and the UART transmitter.
- Stores up to 2^AW words of DB bits in a circular buffer.
- Hands words to the transmitter one at a time using a tx_start / tx_done handshake.
- Reports full, empty, fill level and overflow.
- Replaces the single-word transmit holding stage; sits between the bus interface and the UART TX shift engine.

## Interface
- DB, 8: data word width in bits.
- AW, 4: address width; depth DEPTH = 2^AW words (AW ≥ 1).
- WR_MODE, 0: 0 = wr is a per-cycle strobe (one write per clock with wr=1); 1 = write on wr rising edge only (held wr writes once).
- clk  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr  in  1  write request from CPU side.
- w_data  in  DB  write data, sampled with wr.
- tx_done  in  1  one-cycle pulse from transmitter: current frame finished, transmitter idle.
- d_in  out  DB  word presented to transmitter; registered; stable from tx_start until the next pop.
- tx_start  out  1  one-cycle pulse: transmitter shall load d_in.
- tx_full  out  1  count == DEPTH.
- tx_empty  out  1  count == 0.
- level  out  AW+1  number of stored words, 0..DEPTH.
- overflow  out  1  one-cycle pulse when a write request is dropped because the FIFO is full.

## Operation
- Storage: mem[DEPTH], wr_ptr and rd_ptr (AW bits each, wrap modulo DEPTH), count (AW+1 bits).
- Write qualification: wr_req = wr (WR_MODE=0) or wr & ~wr_q (WR_MODE=1; wr_q is wr registered, reset 0).
- Write acceptance:
  - Accepted iff wr_req and count < DEPTH, both evaluated before the clock edge.
  - Accepted write: mem[wr_ptr] <= w_data, wr_ptr++.
  - wr_req with count == DEPTH: no state change; overflow=1 next cycle.
- Read FSM, states:
  - IDLE: transmitter idle. If count > 0, pop on this edge: d_in <= mem[rd_ptr], rd_ptr++; next state START. Otherwise stay.
  - START: tx_start=1 for this cycle only; next state WAIT.
  - WAIT: stay until tx_done=1, then IDLE.
- tx_done in IDLE or START is ignored.
- After reset the transmitter is idle, so the FSM starts in IDLE.
- Count update: +1 on accepted write only, −1 on pop only, unchanged on both in the same cycle.
- Simultaneous write and pop with count == DEPTH: write rejected (full sampled before the edge), pop proceeds, count → DEPTH−1, overflow pulses.
- Simultaneous write and pop with count == 0 cannot occur: the pop requires count > 0.
- Pointer wrap: AW−1 all-ones → 0; no special handling.
- Reset (any time, including mid-frame):
  - Pointers, count, wr_q and FSM cleared; FSM → IDLE.
  - d_in=0, tx_start=0, tx_full=0, tx_empty=1, level=0, overflow=0.
  - Stored words are discarded; mem contents need not be cleared.
  - A tx_done arriving after reset from a frame still in flight is ignored (FSM in IDLE).

## Timing
- All outputs registered or decoded directly from registers; no combinational path from wr/tx_done to outputs.
- Write-to-empty latency: write accepted at edge N → tx_empty=0, level=1 after N.
  - Pop at edge N+1; d_in valid and tx_start=1 during cycle N+1..N+2.
  - First tx_start is 2 cycles after the wr cycle.
- Back-to-back words: tx_done pulse at edge M → IDLE after M; next pop at M+1; tx_start high in cycle M+1..M+2.
- Minimum inter-start spacing is 3 clocks plus transmitter frame time.
- tx_start is never high for two consecutive cycles.
- tx_full/tx_empty/level reflect count after the same edge that updates count.

## Test plan
- Reset with wr=0 → tx_empty=1, tx_full=0, level=0, tx_start=0, d_in=0, overflow=0; release reset, idle 10 cycles → no tx_start.
- DB=8, AW=2, WR_MODE=0, transmitter model answering tx_done 20 cycles after each tx_start:
  - Write 0x11,0x22,0x33 on consecutive cycles → exactly three tx_start pulses with d_in 0x11, 0x22, 0x33 in order.
  - First tx_start 2 cycles after the first wr.
- Fill with tx_done held 0:
  - Write 0xA0..0xA5 → 0xA0 popped; level peaks at 4 with tx_full=1.
  - Next write gives one overflow pulse per rejected word; level stays 4.
  - Release tx_done pulses → remaining words appear in order, no corruption.
- Wrap-around: stream 40 words (0x00..0x27) with random wr gaps and random tx_done delay → output sequence identical to input; level never exceeds 4.
- WR_MODE=1: hold wr=1 for 5 cycles with w_data=0x5A → exactly one word stored (level peak 1) and one tx_start with d_in=0x5A.
- Reset mid-operation: 3 words queued, FSM in WAIT → assert reset_n=0 for 1 cycle → level=0, tx_start=0; a later stray tx_done produces no tx_start; a new write 0x77 transmits normally.
